// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - game-flow FSM sequencing match check, reveal, move, win check and turn hand-over.
// Every output is a register loaded from the next-state logic, so pulses are clean single cycles.
module turn_sequencer #(
  parameter int REVEAL_CYCLES = 25000000,
  parameter int CNT_W         = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_flip,
  input  logic [3:0] tile_sel,
  input  logic [1:0] N,
  input  logic       go,
  input  logic       W,
  output logic       check_req,
  output logic [3:0] tile_latched,
  output logic       reveal_on,
  output logic       move_en,
  output logic       next_turn,
  output logic       game_rst,
  output logic [1:0] cur_player,
  output logic       winner_valid,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_PICK = 3'd1,
    S_CHECK     = 3'd2,
    S_REVEAL    = 3'd3,
    S_ADVANCE   = 3'd4,
    S_WINCHK    = 3'd5,
    S_PASS      = 3'd6,
    S_GAMEOVER  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(REVEAL_CYCLES - 1);

  state_t           r_state, w_state;
  logic [1:0]       r_phase, w_phase;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_match, w_match;
  logic [1:0]       r_last, w_last;   // highest player index: players-1
  logic [1:0]       r_cur, w_cur;
  logic [3:0]       r_tile, w_tile;
  logic [1:0]       r_win, w_win;
  logic             r_wv, w_wv;
  logic             r_reveal, w_reveal;
  logic             r_check, w_check;
  logic             r_move, w_move;
  logic             r_next, w_next;
  logic             r_grst, w_grst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_phase  <= 2'd0;
      r_cnt    <= '0;
      r_match  <= 1'b0;
      r_last   <= 2'd1;
      r_cur    <= 2'd0;
      r_tile   <= 4'd0;
      r_win    <= 2'd0;
      r_wv     <= 1'b0;
      r_reveal <= 1'b0;
      r_check  <= 1'b0;
      r_move   <= 1'b0;
      r_next   <= 1'b0;
      r_grst   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_phase  <= w_phase;
      r_cnt    <= w_cnt;
      r_match  <= w_match;
      r_last   <= w_last;
      r_cur    <= w_cur;
      r_tile   <= w_tile;
      r_win    <= w_win;
      r_wv     <= w_wv;
      r_reveal <= w_reveal;
      r_check  <= w_check;
      r_move   <= w_move;
      r_next   <= w_next;
      r_grst   <= w_grst;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_phase  = r_phase;
    w_cnt    = r_cnt;
    w_match  = r_match;
    w_last   = r_last;
    w_cur    = r_cur;
    w_tile   = r_tile;
    w_win    = r_win;
    w_wv     = r_wv;
    w_reveal = r_reveal;
    w_check  = 1'b0;
    w_move   = 1'b0;
    w_next   = 1'b0;
    w_grst   = 1'b0;
    case (r_state)
      S_IDLE, S_GAMEOVER: begin
        if (btn_start) begin
          w_state = S_WAIT_PICK;
          w_grst  = 1'b1;
          w_last  = (N == 2'd0) ? 2'd1 : N;
          w_cur   = 2'd0;
          w_wv    = 1'b0;
        end
      end
      S_WAIT_PICK: begin
        if (btn_flip) begin
          w_state = S_CHECK;
          w_tile  = tile_sel;
          w_check = 1'b1;
          w_phase = 2'd0;
        end
      end
      S_CHECK: begin
        // phase 0 is the check_req cycle; go is valid two cycles later
        if (r_phase == 2'd2) begin
          w_match  = go;
          w_state  = S_REVEAL;
          w_reveal = 1'b1;
          w_cnt    = LP_LOAD;
        end else begin
          w_phase = r_phase + 2'd1;
        end
      end
      S_REVEAL: begin
        if (r_cnt == '0) begin
          w_reveal = 1'b0;
          if (r_match) begin
            w_state = S_ADVANCE;
            w_move  = 1'b1;
          end else begin
            w_state = S_PASS;
            w_next  = 1'b1;
          end
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_ADVANCE: w_state = S_WINCHK;
      S_WINCHK: begin
        if (W) begin
          w_win   = r_cur;
          w_wv    = 1'b1;
          w_state = S_GAMEOVER;
        end else begin
          w_state = S_WAIT_PICK;
        end
      end
      S_PASS: begin
        w_cur   = (r_cur == r_last) ? 2'd0 : r_cur + 2'd1;
        w_state = S_WAIT_PICK;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign check_req    = r_check;
  assign tile_latched = r_tile;
  assign reveal_on    = r_reveal;
  assign move_en      = r_move;
  assign next_turn    = r_next;
  assign game_rst     = r_grst;
  assign cur_player   = r_cur;
  assign winner_valid = r_wv;
  assign winner       = r_win;
  assign state        = r_state;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - directed bench for turn_sequencer with REVEAL_CYCLES=4.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_flip = 1'b0;
  logic [3:0] tile_sel = 4'd0;
  logic [1:0] N = 2'd0;
  logic       go = 1'b0;
  logic       W = 1'b0;
  logic       check_req, reveal_on, move_en, next_turn, game_rst, winner_valid;
  logic [3:0] tile_latched;
  logic [1:0] cur_player, winner;
  logic [2:0] state;
  int checks = 0;
  int failures = 0;

  turn_sequencer #(.REVEAL_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_flip(btn_flip),
    .tile_sel(tile_sel), .N(N), .go(go), .W(W),
    .check_req(check_req), .tile_latched(tile_latched), .reveal_on(reveal_on),
    .move_en(move_en), .next_turn(next_turn), .game_rst(game_rst),
    .cur_player(cur_player), .winner_valid(winner_valid), .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_game(input logic [1:0] n);
    @(negedge clk); btn_start = 1'b1; N = n;
    @(negedge clk); btn_start = 1'b0; N = ~n;
    chk("start_state", state, 1);
    chk("start_game_rst", game_rst, 1);
    chk("start_cur", cur_player, 0);
    chk("start_wv", winner_valid, 0);
    @(negedge clk);
    chk("game_rst_one_cycle", game_rst, 0);
  endtask

  // One turn: flip tile, go=g in the check_req+2 cycle only, W=w in WINCHK only.
  task automatic turn(input logic [3:0] tile, input logic g, input logic w,
                      input bit noise, input logic [1:0] exp_cur);
    @(negedge clk); btn_flip = 1'b1; tile_sel = tile; btn_start = noise; go = ~g;
    @(negedge clk); btn_flip = 1'b0; btn_start = noise;
    chk("chk_state", state, 2);
    chk("chk_req", check_req, 1);
    chk("chk_tile", tile_latched, {28'd0, tile});
    chk("chk_no_grst", game_rst, 0);
    @(negedge clk); btn_start = 1'b0;
    chk("chk_state_c1", state, 2);
    chk("chk_req_once", check_req, 0);
    go = g;
    @(negedge clk);
    chk("chk_state_c2", state, 2);
    @(negedge clk); go = ~g;
    for (int i = 0; i < 4; i++) begin
      btn_flip = noise && (i == 0);
      chk("rev_state", state, 3);
      chk("rev_on", reveal_on, 1);
      chk("rev_no_req", check_req, 0);
      @(negedge clk); btn_flip = 1'b0;
    end
    chk("rev_off", reveal_on, 0);
    chk("post_state", state, g ? 4 : 6);
    chk("post_move_en", move_en, {31'd0, g});
    chk("post_next_turn", next_turn, {31'd0, ~g});
    go = 1'b0;
    if (g) begin
      W = ~w;
      @(negedge clk); W = w;
      chk("winchk_state", state, 5);
      chk("move_en_once", move_en, 0);
      @(negedge clk); W = 1'b0;
      chk("end_state", state, w ? 7 : 1);
      chk("end_cur", cur_player, {30'd0, exp_cur});
      if (w) begin
        chk("end_wv", winner_valid, 1);
        chk("end_winner", winner, {30'd0, exp_cur});
      end
    end else begin
      @(negedge clk);
      chk("pass_state", state, 1);
      chk("next_turn_once", next_turn, 0);
      chk("pass_cur", cur_player, {30'd0, exp_cur});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_reveal", reveal_on, 0);
    chk("rst_cur", cur_player, 0);
    chk("rst_tile", tile_latched, 0);
    chk("rst_wv", winner_valid, 0);
    chk("rst_pulses", {check_req, move_en, next_turn, game_rst}, 0);
    rst = 1'b0;
    @(negedge clk); btn_flip = 1'b1;
    @(negedge clk); btn_flip = 1'b0;
    chk("idle_flip_ignored", state, 0);

    start_game(2'd2);
    turn(4'd5, 1'b1, 1'b0, 1'b0, 2'd0);
    turn(4'd3, 1'b0, 1'b0, 1'b0, 2'd1);
    turn(4'd7, 1'b0, 1'b0, 1'b0, 2'd2);
    turn(4'd9, 1'b0, 1'b0, 1'b0, 2'd0);
    turn(4'd2, 1'b0, 1'b0, 1'b0, 2'd1);
    turn(4'd4, 1'b1, 1'b1, 1'b0, 2'd1);

    @(negedge clk); btn_flip = 1'b1;
    @(negedge clk); btn_flip = 1'b0;
    chk("over_flip_state", state, 7);
    chk("over_flip_req", check_req, 0);
    chk("over_winner_held", winner, 1);

    start_game(2'd0);
    turn(4'd1, 1'b0, 1'b0, 1'b1, 2'd1);
    turn(4'd6, 1'b0, 1'b0, 1'b0, 2'd0);

    @(negedge clk); btn_flip = 1'b1; tile_sel = 4'd8; go = 1'b1;
    @(negedge clk); btn_flip = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_state", state, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_reveal", reveal_on, 0);
    chk("async_rst_tile", tile_latched, 0);
    @(negedge clk); rst = 1'b0; go = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {move_en, next_turn, check_req, game_rst}, 0);
      chk("post_rst_state", state, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
